// File: rtl/msg_pkg.sv
// Shared types and defaults for the parsed-message sink path.
package msg_pkg;

    localparam int MAX_PKT_LENGTH = 256;
    localparam int MIN_PKT_LENGTH = 64;
    localparam int MSG_LEN_W      = 16;

    typedef struct packed {
        logic [MSG_LEN_W-1:0]      length;
        logic [MAX_PKT_LENGTH-1:0] data;
    } msg_t;

    typedef enum logic [1:0] {
        NONE,
        ERR,
        LEN,
        FULL
    } drop_cause_e;

endpackage

// File: rtl/msg_fifo_mem.sv
// Message storage: one synchronous write port, combinational read port so the
// FIFO head is available show-ahead.
module msg_fifo_mem
    import msg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(msg_t)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/msg_sink_fifo.sv
// Show-ahead message FIFO behind msg_parser; drops errored, illegal-length or
// overflowing messages. Define MSG_SINK_FIFO_STATS_EN for saturating statistics.
module msg_sink_fifo
    import msg_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int MAX_PKT_LENGTH = msg_pkg::MAX_PKT_LENGTH,
    parameter int MIN_PKT_LENGTH = msg_pkg::MIN_PKT_LENGTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [MSG_LEN_W-1:0]       in_length,
    input  logic [MAX_PKT_LENGTH-1:0]  in_data,
    input  logic                       in_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MSG_LEN_W-1:0]       out_length,
    output logic [MAX_PKT_LENGTH-1:0]  out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       drop_pulse,
    output logic                       overflow,
    input  logic                       overflow_clr
`ifdef MSG_SINK_FIFO_STATS_EN
    ,
    output logic [31:0]                stat_accepted,
    output logic [31:0]                stat_dropped_error,
    output logic [31:0]                stat_dropped_full
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int NBYTES = MAX_PKT_LENGTH / 8;
    localparam int MEM_W  = MSG_LEN_W + MAX_PKT_LENGTH;
    localparam logic [MSG_LEN_W-1:0] LEN_MIN = MSG_LEN_W'(MIN_PKT_LENGTH / 8);
    localparam logic [MSG_LEN_W-1:0] LEN_MAX = MSG_LEN_W'(MAX_PKT_LENGTH / 8);

    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [LVL_W-1:0]          level_reg;
    logic                      drop_pulse_reg;
    logic                      overflow_reg;
    logic [MAX_PKT_LENGTH-1:0] masked_data;
    logic [MEM_W-1:0]          rd_word;
    logic                      push;
    logic                      pop;
    logic                      len_ok;
    drop_cause_e               cause;

    assign out_valid = (level_reg != '0);
    assign full      = (level_reg == LVL_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign len_ok    = (in_length >= LEN_MIN) && (in_length <= LEN_MAX);

    // First failing check names the cause, so a message is dropped exactly once.
    always_comb begin
        cause = NONE;
        if (in_valid) begin
            if (in_error) begin
                cause = ERR;
            end else if (!len_ok) begin
                cause = LEN;
            end else if (full && !pop) begin
                cause = FULL;
            end
        end
    end

    assign push = in_valid && (cause == NONE);

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_mask
            assign masked_data[8*gi +: 8] =
                (MSG_LEN_W'(gi) < in_length) ? in_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    msg_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data ({in_length, masked_data}),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_word)
    );

    // Storage is not reset, so the head is forced to zero while empty.
    assign out_length = out_valid ? rd_word[MEM_W-1 -: MSG_LEN_W] : '0;
    assign out_data   = out_valid ? rd_word[MAX_PKT_LENGTH-1:0] : '0;
    assign level      = level_reg;
    assign drop_pulse = drop_pulse_reg;
    assign overflow   = overflow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            drop_pulse_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg      <= level_reg + LVL_W'(push) - LVL_W'(pop);
            drop_pulse_reg <= (cause != NONE);
            if (cause == FULL) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef MSG_SINK_FIFO_STATS_EN
    logic [31:0] acc_reg;
    logic [31:0] derr_reg;
    logic [31:0] dfull_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            derr_reg  <= '0;
            dfull_reg <= '0;
        end else begin
            if (push && (acc_reg != '1)) begin
                acc_reg <= acc_reg + 32'd1;
            end
            if (((cause == ERR) || (cause == LEN)) && (derr_reg != '1)) begin
                derr_reg <= derr_reg + 32'd1;
            end
            if ((cause == FULL) && (dfull_reg != '1)) begin
                dfull_reg <= dfull_reg + 32'd1;
            end
        end
    end

    assign stat_accepted      = acc_reg;
    assign stat_dropped_error = derr_reg;
    assign stat_dropped_full  = dfull_reg;
`endif

endmodule

// File: doc/msg_sink_fifo.md
Name: msg_sink_fifo

Overview:
- Sits directly downstream of msg_parser.
- Captures every parsed message (msg_valid/msg_length/msg_data/msg_error) into a small show-ahead FIFO.
- Presents messages to the application side through a valid/ready handshake.
- msg_parser has no output backpressure, so this block absorbs bursts and drops and counts messages it cannot or must not store: errored, illegal length, or arriving while full.

Parameters:
- DEPTH, 4, number of message entries; power of two, ≥2.
- MAX_PKT_LENGTH, 256, msg_data width in bits (max message 32 bytes).
- MIN_PKT_LENGTH, 64, minimum legal message size in bits (8 bytes).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  msg_valid from parser, one-cycle pulse per message
- in_length  in  16  message length in bytes
- in_data  in  MAX_PKT_LENGTH  payload; byte k in bits [8k+7:8k]
- in_error  in  1  parser error flag, qualified by in_valid
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_length  out  16  head length in bytes
- out_data  out  MAX_PKT_LENGTH  head payload, bytes ≥ out_length zeroed
- level  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  level == DEPTH
- drop_pulse  out  1  one-cycle pulse when an incoming message is discarded
- overflow  out  1  sticky: a message was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Read and write pointers = 0, level = 0.
  - out_valid = 0, full = 0, drop_pulse = 0, overflow = 0.
  - out_length and out_data read as 0 while empty.
- Legal length: MIN_PKT_LENGTH/8 ≤ in_length ≤ MAX_PKT_LENGTH/8, i.e. 8..32 bytes.
- Push on in_valid when all of the following hold:
  - in_error = 0
  - length is legal
  - not full, OR full with a pop in the same cycle
- Stored payload: bytes at index ≥ in_length are zeroed before the write.
- Drop on in_valid when any push condition fails:
  - drop_pulse = 1 on the following cycle.
  - overflow is set only when the cause is full, with no error and a legal length.
- Error precedence: in_error, then length, then full. A message is dropped at most once, with one cause.
- Pop: out_valid && out_ready. Read pointer advances, level decrements.
- out_valid = (level != 0). The head is combinational from storage (show-ahead).
- Latency: an entry pushed in cycle N is visible at out_valid/out_data in cycle N+1.
- Handshake rules:
  - out_data and out_length hold stable while out_valid && !out_ready.
  - out_valid never deasserts without a pop.
- Simultaneous push and pop: level unchanged, both pointers advance. Legal at full and at non-empty.
- Push while empty with out_ready high: the entry is not bypassed; the pop occurs at the earliest in N+1.
- Pointers are log2(DEPTH) bits and wrap naturally. level is computed separately, so full and empty are never ambiguous.
- overflow_clr and a new overflow drop in the same cycle: set wins, so overflow stays 1.
- in_valid while rst is asserted is ignored.

Optional Feature:
- MSG_SINK_FIFO_STATS_EN adds three 32-bit saturating counters:
  - stat_accepted
  - stat_dropped_error (error or illegal length)
  - stat_dropped_full
- Counters clear on rst and saturate at 0xFFFFFFFF.
- Without the macro: ports absent, no counter logic, functional behaviour identical.

Decomposition:
- Package msg_pkg holds:
  - MAX_PKT_LENGTH and MIN_PKT_LENGTH defaults
  - MSG_LEN_W = 16
  - typedef msg_t struct packed {length, data}
  - typedef drop_cause_e enum {NONE, ERR, LEN, FULL}
- Sub-module msg_fifo_mem: DEPTH×msg_t storage, one write port, asynchronous read port.
- Pointer, level, drop and overflow logic live in msg_sink_fifo.

Test Plan:
- Single message: in_length=8, in_data=0x630d658d_abcddcef, in_valid pulse, out_ready=0.
  - Next cycle: out_valid=1, out_length=8, out_data identical, level=1.
  - Hold 5 cycles, data stable. out_ready=1 → empty next cycle.
- Masking: in_length=10, all 32 bytes 0xA5 → out_data bytes 0..9 = 0xA5, bytes 10..31 = 0.
- Fill and overflow (DEPTH=4), out_ready=0, push 5 legal messages:
  - level=4, full=1.
  - 5th message: drop_pulse=1, overflow=1.
  - The first 4 messages drain in order.
  - overflow_clr → overflow=0.
- Full with simultaneous push and pop: level stays 4, no drop, order preserved.
- Filtering:
  - in_error=1 → drop_pulse, no push, overflow stays 0.
  - in_length=7 → dropped.
  - in_length=33 → dropped.
  - in_length=32 → accepted.
- Reset mid-operation: level=3, assert rst asynchronously between clock edges → out_valid=0 and level=0 immediately. A post-reset push works normally.
